// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48E2 operand staging blocks: C-path width,
// zero-extension helper and parameter legality checks.
package dsp_pkg;

   localparam int DSP_C_WIDTH = 48;

   // Clears every bit at or above 'width' so a narrow operand reaches the
   // C port with its upper bits forced to zero.
   function automatic logic [DSP_C_WIDTH-1:0] dsp_zext(input logic [DSP_C_WIDTH-1:0] value,
                                                       input int width);
      logic [DSP_C_WIDTH-1:0] mask;
      mask = '0;
      for (int i = 0; i < DSP_C_WIDTH; i++) begin
         if (i < width) mask[i] = 1'b1;
      end
      return value & mask;
   endfunction

   // Staging buffers use power-of-two depths from 2 to 16 so the
   // pointers wrap naturally.
   function automatic bit dsp_depth_ok(input int depth);
      return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
   endfunction

   // Operands must fit the 48-bit C path.
   function automatic bit dsp_width_ok(input int width);
      return (width >= 1) && (width <= DSP_C_WIDTH);
   endfunction

endpackage

// File: rtl/dsp_in_fifo_if.sv
// Handshake bundle for dsp_in_fifo: the producer side (in_*), the DSP
// consumer side (out_*) and the occupancy count.
interface dsp_in_fifo_if
   import dsp_pkg::*;
#(
   parameter int width = 48,
   parameter int depth = 4
);

   logic                       in_valid;
   logic                       in_ready;
   logic [width-1:0]           in_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [DSP_C_WIDTH-1:0]     out_data;
   logic [$clog2(depth):0]     count;

   // Environment view: drives operands in and consumes the head entry.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   // Buffer view.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );

endinterface

// File: rtl/dsp_in_fifo_mem.sv
// depth x width register file: one synchronous write port and one
// asynchronous read port. Storage is deliberately left without reset.
module dsp_in_fifo_mem #(
   parameter int width = 48,
   parameter int depth = 4
) (
   input  logic                       clock,
   input  logic                       i_wrEn,
   input  logic [$clog2(depth)-1:0]   i_wrAddr,
   input  logic [width-1:0]           i_wrData,
   input  logic [$clog2(depth)-1:0]   i_rdAddr,
   output logic [width-1:0]           o_rdData
);

   logic [width-1:0] r_mem [depth];

   // Capture the operand into the addressed entry on an accepted push.
   always_ff @(posedge clock) begin
      if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
   end

   assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/dsp_in_fifo.sv
// First-word-fall-through operand buffer in front of the combinational DSP
// C-path. Pointers and occupancy live here; in_ready/out_valid decode only
// from the registered count, so the two handshakes never chain.
module dsp_in_fifo
   import dsp_pkg::*;
#(
   parameter int width = 48,
   parameter int depth = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           flush,
   dsp_in_fifo_if.slave   bus
);

   localparam int PW = $clog2(depth);
   localparam int CW = PW + 1;

   generate
      if (!dsp_width_ok(width)) begin : g_badWidth
         $error("dsp_in_fifo: width %0d outside 1..48", width);
      end
      if (!dsp_depth_ok(depth)) begin : g_badDepth
         $error("dsp_in_fifo: depth %0d must be a power of two in 2..16", depth);
      end
   endgenerate

   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [width-1:0] w_head;

   assign w_full  = (r_count == CW'(depth));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.in_valid & ~w_full & ~flush;
   assign w_pop   = ~w_empty & bus.out_ready & ~flush;

   assign bus.in_ready  = ~w_full;
   assign bus.out_valid = ~w_empty;
   assign bus.count     = r_count;

   dsp_in_fifo_mem #(
      .width (width),
      .depth (depth)
   ) u_mem (
      .clock    (clock),
      .i_wrEn   (w_push),
      .i_wrAddr (r_wrPtr),
      .i_wrData (bus.in_data),
      .i_rdAddr (r_rdPtr),
      .o_rdData (w_head)
   );

   // Advance pointers on push/pop and track occupancy; flush wins over
   // both and simply discards whatever handshake was in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   assign bus.out_data = w_empty ? '0 : dsp_zext(DSP_C_WIDTH'(w_head), width);

endmodule

// File: tb/tb_dsp_in_fifo.sv
// Scoreboard bench for dsp_in_fifo (width=8, depth=4). Directed stimulus
// queues the expected head values; a negedge monitor pops and compares on
// every DUT transfer.
module tb_dsp_in_fifo;
   import dsp_pkg::*;

   localparam int W = 8;
   localparam int D = 4;

   logic clock;
   logic reset;
   logic flush;

   int vecCount  = 0;
   int missCount = 0;
   logic [47:0] expQ[$];

   dsp_in_fifo_if #(.width(W), .depth(D)) bus();

   dsp_in_fifo #(.width(W), .depth(D)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one value and log a miscompare with its name.
   task automatic checkOutput(input string name, input logic [47:0] actual,
                              input logic [47:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then return 1ns after the next rising edge.
   task automatic applyStimulus(input logic inV, input logic [W-1:0] inD,
                                input logic outR, input logic fl);
      bus.in_valid  = inV;
      bus.in_data   = inD;
      bus.out_ready = outR;
      flush         = fl;
      @(posedge clock);
      #1;
   endtask

   task automatic checkIdleEmpty(input string tag);
      checkOutput({tag, "_count"},    48'(bus.count), 48'd0);
      checkOutput({tag, "_inReady"},  48'(bus.in_ready), 48'd1);
      checkOutput({tag, "_outValid"}, 48'(bus.out_valid), 48'd0);
      checkOutput({tag, "_outData"},  bus.out_data, 48'd0);
   endtask

   // Monitor: every transfer the DUT completes must match the queue head.
   always @(negedge clock) begin
      if (!reset && !flush && bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no entry", bus.out_data);
         end else begin
            checkOutput("pop_data", bus.out_data, expQ.pop_front());
         end
      end
   end

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #3;
      checkIdleEmpty("reset");
      @(posedge clock);
      #1 reset = 1'b0;

      // Idle after reset.
      applyStimulus(0, 8'h00, 0, 0);
      checkIdleEmpty("idle");

      // Single push shows up first-word-fall-through, zero-extended.
      expQ.push_back(48'h0000_0000_00A5);
      applyStimulus(1, 8'hA5, 0, 0);
      bus.in_valid = 1'b0;
      checkOutput("push1_valid", 48'(bus.out_valid), 48'd1);
      checkOutput("push1_data",  bus.out_data, 48'h0000_0000_00A5);
      checkOutput("push1_count", 48'(bus.count), 48'd1);
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("drain1_count", 48'(bus.count), 48'd0);

      // Fill to full, hold the fifth word, then pop one to make room.
      for (int i = 1; i <= 4; i++) begin
         expQ.push_back(48'(i));
         applyStimulus(1, 8'(i), 0, 0);
      end
      checkOutput("full_count",   48'(bus.count), 48'd4);
      checkOutput("full_inReady", 48'(bus.in_ready), 48'd0);
      applyStimulus(1, 8'h05, 0, 0);
      checkOutput("held_count", 48'(bus.count), 48'd4);
      applyStimulus(1, 8'h05, 1, 0);
      checkOutput("popfull_count",   48'(bus.count), 48'd3);
      checkOutput("popfull_inReady", 48'(bus.in_ready), 48'd1);
      expQ.push_back(48'h05);
      applyStimulus(1, 8'h05, 0, 0);
      checkOutput("refill_count", 48'(bus.count), 48'd4);
      for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0);
      checkOutput("drain5_count", 48'(bus.count), 48'd0);

      // Simultaneous push/pop at count=2 for ten cycles; pointers wrap.
      expQ.push_back(48'h10);
      applyStimulus(1, 8'h10, 0, 0);
      expQ.push_back(48'h11);
      applyStimulus(1, 8'h11, 0, 0);
      for (int i = 0; i < 10; i++) begin
         expQ.push_back(48'(8'h12 + i));
         applyStimulus(1, 8'(8'h12 + i), 1, 0);
         checkOutput("stream_count", 48'(bus.count), 48'd2);
      end
      applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("stream_drained", 48'(bus.count), 48'd0);

      // Flush at count=3 with push and pop requested: everything discarded.
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h20 + i), 0, 0);
      checkOutput("preflush_count", 48'(bus.count), 48'd3);
      expQ.delete();
      applyStimulus(1, 8'h99, 1, 1);
      bus.in_valid = 1'b0;
      checkIdleEmpty("flush");
      for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);
      checkOutput("postflush_count", 48'(bus.count), 48'd0);

      // Asynchronous reset mid-cycle at count=3, then one clean push.
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h30 + i), 0, 0);
      bus.in_valid = 1'b0;
      #2 reset = 1'b1;
      expQ.delete();
      #1;
      checkIdleEmpty("midReset");
      @(posedge clock);
      #1 reset = 1'b0;
      expQ.push_back(48'h3C);
      applyStimulus(1, 8'h3C, 0, 0);
      checkOutput("afterReset_count", 48'(bus.count), 48'd1);
      checkOutput("afterReset_data",  bus.out_data, 48'h3C);
      applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("afterReset_empty", 48'(bus.count), 48'd0);

      checkOutput("scoreboard_left", 48'(expQ.size()), 48'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
